// File: rtl/multi_pop_fifo_if.sv
// Handshake bundle for multi_pop_fifo: one-word push side, multi-lane pop side.
// The FIFO takes the slave modport; the producer/consumer takes master.
interface multi_pop_fifo_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned POP_WIDTH  = 4,
   parameter int unsigned ELEMENTS   = 15
);
   localparam int unsigned CT_W  = $clog2(POP_WIDTH) + 1;
   localparam int unsigned CNT_W = $clog2(ELEMENTS + 1);

   logic [DATA_WIDTH-1:0]           din;
   logic                            din_valid;
   logic                            din_ready;
   logic [DATA_WIDTH*POP_WIDTH-1:0] dout;
   logic [CT_W-1:0]                 dout_valid_ct;
   logic [CT_W-1:0]                 dout_ready_ct;
   logic [CNT_W-1:0]                count;

   modport master (
      output din, din_valid, dout_ready_ct,
      input  din_ready, dout, dout_valid_ct, count
   );

   modport slave (
      input  din, din_valid, dout_ready_ct,
      output din_ready, dout, dout_valid_ct, count
   );
endinterface

// File: rtl/multi_pop_fifo.sv
// FIFO with one push and up to POP_WIDTH pops per cycle; lane 0 is always the oldest entry.
// Define MULTI_POP_FIFO_BYPASS_EN to let a push appear on dout (and be popped) in the same cycle.
module multi_pop_fifo #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned POP_WIDTH  = 4,
   parameter int unsigned ELEMENTS   = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   multi_pop_fifo_if.slave  bus
);
   localparam int unsigned CT_W  = $clog2(POP_WIDTH) + 1;
   localparam int unsigned CNT_W = $clog2(ELEMENTS + 1);
   localparam int unsigned PTR_W = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;
   localparam int unsigned SUM_W = PTR_W + 1;

   localparam logic [CNT_W-1:0] POP_CNT  = CNT_W'(POP_WIDTH);
   localparam logic [CNT_W-1:0] ELEM_CNT = CNT_W'(ELEMENTS);
   localparam logic [SUM_W-1:0] ELEM_SUM = SUM_W'(ELEMENTS);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(ELEMENTS - 1);

   logic [DATA_WIDTH-1:0] mem [ELEMENTS];

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;

   logic             push;
   logic             byp_lane;
   logic             byp_take;
   logic             wr_en;
   logic [CT_W-1:0]  stored_lanes;
   logic [CT_W-1:0]  valid_ct;
   logic [CT_W-1:0]  pops;
   logic [CT_W-1:0]  rd_adv;
   logic [SUM_W-1:0] rd_sum;
   logic [PTR_W-1:0] rd_ptr_nxt;
   logic [PTR_W-1:0] wr_ptr_nxt;
   logic [CNT_W-1:0] count_nxt;

   logic [SUM_W-1:0] lane_sum  [POP_WIDTH];
   logic [PTR_W-1:0] lane_addr [POP_WIDTH];

   // Space check looks only at registered occupancy, never at same-cycle pops.
   assign bus.din_ready = rst_n && (count < ELEM_CNT);
   assign push          = bus.din_valid && bus.din_ready;
   assign stored_lanes  = (count < POP_CNT) ? CT_W'(count) : CT_W'(POP_WIDTH);

`ifdef MULTI_POP_FIFO_BYPASS_EN
   // Incoming word rides in the first lane above the stored ones while storage is shallow.
   assign byp_lane = push && (count < POP_CNT);
`else
   assign byp_lane = 1'b0;
`endif

   assign valid_ct          = rst_n ? (stored_lanes + CT_W'(byp_lane)) : '0;
   assign bus.dout_valid_ct = valid_ct;
   assign pops              = (valid_ct < bus.dout_ready_ct) ? valid_ct : bus.dout_ready_ct;

   // A bypassed word that gets popped never touches storage, so rd_ptr skips it too.
   assign byp_take = byp_lane && (pops > stored_lanes);
   assign wr_en    = push && !byp_take;
   assign rd_adv   = pops - CT_W'(byp_take);

   assign rd_sum     = SUM_W'(rd_ptr) + SUM_W'(rd_adv);
   assign rd_ptr_nxt = (rd_sum >= ELEM_SUM) ? PTR_W'(rd_sum - ELEM_SUM) : PTR_W'(rd_sum);
   assign wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : (wr_ptr + PTR_W'(1));
   assign count_nxt  = count + CNT_W'(push) - CNT_W'(pops);

   assign bus.count = count;

   // Storage address of each output lane, wrapping at ELEMENTS.
   always_comb begin
      for (int k = 0; k < POP_WIDTH; k++) begin
         lane_sum[k]  = SUM_W'(rd_ptr) + SUM_W'(k);
         lane_addr[k] = (lane_sum[k] >= ELEM_SUM) ? PTR_W'(lane_sum[k] - ELEM_SUM)
                                                  : PTR_W'(lane_sum[k]);
      end
   end

   always_comb begin
      bus.dout = '0;
      for (int k = 0; k < POP_WIDTH; k++) begin
         if (byp_lane && (CT_W'(k) == stored_lanes))
            bus.dout[k*DATA_WIDTH +: DATA_WIDTH] = bus.din;
         else
            bus.dout[k*DATA_WIDTH +: DATA_WIDTH] = mem[lane_addr[k]];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr_nxt;
         count  <= count_nxt;
         if (wr_en)
            wr_ptr <= wr_ptr_nxt;
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= bus.din;
   end
endmodule

// File: tb/tb_multi_pop_fifo.sv
// Scoreboard bench for multi_pop_fifo: stimulus queues expected words, a monitor retires them.
// Build with or without MULTI_POP_FIFO_BYPASS_EN; expectations switch accordingly.
module tb_multi_pop_fifo;
   localparam int unsigned DW = 32;
   localparam int unsigned PW = 4;
   localparam int unsigned EL = 15;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   multi_pop_fifo_if #(.DATA_WIDTH(DW), .POP_WIDTH(PW), .ELEMENTS(EL)) bus ();

   multi_pop_fifo #(.DATA_WIDTH(DW), .POP_WIDTH(PW), .ELEMENTS(EL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [DW-1:0] exp_q [$];
   int checks = 0;
   int errors = 0;
   bit mon_stop = 1'b0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
      end
   endfunction

   function automatic logic [DW-1:0] lane(int k);
      return bus.dout[k*DW +: DW];
   endfunction

   // Inputs change 1 time unit after the active edge and hold until the next one.
   task automatic drive(bit v, logic [DW-1:0] d, int r);
      @(posedge clk);
      #1;
      bus.din_valid     = v;
      bus.din           = d;
      bus.dout_ready_ct = 3'(r);
   endtask

   // Retires popped lanes against the expected-order queue on every falling edge.
   task automatic monitor();
      int vct;
      int rct;
      int p;
      logic [DW-1:0] e;
      forever begin
         @(negedge clk);
         if (mon_stop) break;
         vct = int'(bus.dout_valid_ct);
         rct = int'(bus.dout_ready_ct);
         p   = (vct < rct) ? vct : rct;
         for (int i = 0; i < p; i++) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL monitor_underflow lane=%0d actual=0x%0h required=none", i, lane(i));
            end else begin
               e = exp_q.pop_front();
               check("lane_data", 64'(lane(i)), 64'(e));
            end
         end
      end
   endtask

   initial begin
      int mcnt;
      int sent;
      int cyc;
      int r;
      int stored;
      int vct;
      int pops;
      bit v;
      bit acc;

      rst_n             = 1'b0;
      bus.din_valid     = 1'b1;
      bus.din           = 32'hDEAD;
      bus.dout_ready_ct = '0;
      fork
         monitor();
      join_none

      // Reset held two cycles with a push request pending.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_din_ready", 64'(bus.din_ready), 0);
      check("rst_valid_ct", 64'(bus.dout_valid_ct), 0);
      @(posedge clk);
      #1;
      rst_n         = 1'b1;
      bus.din_valid = 1'b0;
      @(negedge clk);
      check("post_rst_count", 64'(bus.count), 0);
      check("post_rst_din_ready", 64'(bus.din_ready), 1);
      check("post_rst_valid_ct", 64'(bus.dout_valid_ct), 0);

      // Five pushes, then a 3-lane pop.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h11 + 32'(i), 0);
         exp_q.push_back(32'h11 + 32'(i));
      end
      drive(1'b0, '0, 0);
      @(negedge clk);
      check("t2_count", 64'(bus.count), 5);
      check("t2_valid_ct", 64'(bus.dout_valid_ct), 4);
      check("t2_lane0", 64'(lane(0)), 64'h11);
      check("t2_lane1", 64'(lane(1)), 64'h12);
      check("t2_lane2", 64'(lane(2)), 64'h13);
      check("t2_lane3", 64'(lane(3)), 64'h14);
      drive(1'b0, '0, 3);
      drive(1'b0, '0, 0);
      @(negedge clk);
      check("t2_count_after_pop", 64'(bus.count), 2);
      check("t2_valid_ct_after_pop", 64'(bus.dout_valid_ct), 2);
      check("t2_lane0_after_pop", 64'(lane(0)), 64'h14);
      check("t2_lane1_after_pop", 64'(lane(1)), 64'h15);
      drive(1'b0, '0, 2);
      drive(1'b0, '0, 0);
      @(negedge clk);
      check("t2_drained", 64'(bus.count), 0);

      // Fill to full, then a push attempt against a simultaneous pop is dropped.
      for (int i = 0; i < 15; i++) begin
         drive(1'b1, 32'h20 + 32'(i), 0);
         exp_q.push_back(32'h20 + 32'(i));
      end
      drive(1'b0, '0, 0);
      @(negedge clk);
      check("t3_full_count", 64'(bus.count), 15);
      check("t3_full_din_ready", 64'(bus.din_ready), 0);
      check("t3_full_valid_ct", 64'(bus.dout_valid_ct), 4);
      drive(1'b1, 32'h99, 1);
      @(negedge clk);
      check("t3_full_pop_din_ready", 64'(bus.din_ready), 0);
      drive(1'b0, '0, 0);
      @(negedge clk);
      check("t3_after_drop_count", 64'(bus.count), 14);
      check("t3_after_drop_din_ready", 64'(bus.din_ready), 1);
      check("t3_after_drop_lane0", 64'(lane(0)), 64'h21);
      repeat (4) drive(1'b0, '0, 4);
      drive(1'b0, '0, 0);
      @(negedge clk);
      check("t3_drained", 64'(bus.count), 0);

      // Push into an empty FIFO with a 1-lane consumer.
      drive(1'b1, 32'hAA, 1);
      exp_q.push_back(32'hAA);
      @(negedge clk);
`ifdef MULTI_POP_FIFO_BYPASS_EN
      check("t5_byp_valid_ct", 64'(bus.dout_valid_ct), 1);
      check("t5_byp_lane0", 64'(lane(0)), 64'hAA);
      drive(1'b0, '0, 0);
      @(negedge clk);
      check("t5_byp_count", 64'(bus.count), 0);
      check("t5_byp_valid_ct_after", 64'(bus.dout_valid_ct), 0);
`else
      check("t5_valid_ct", 64'(bus.dout_valid_ct), 0);
      drive(1'b0, '0, 0);
      @(negedge clk);
      check("t5_lane0_next", 64'(lane(0)), 64'hAA);
      check("t5_count_next", 64'(bus.count), 1);
      check("t5_valid_ct_next", 64'(bus.dout_valid_ct), 1);
      drive(1'b0, '0, 1);
      drive(1'b0, '0, 0);
      @(negedge clk);
      check("t5_drained", 64'(bus.count), 0);
`endif

      // Wide consumer against two stored words, without and with a same-cycle push.
      drive(1'b1, 32'h01, 0);
      exp_q.push_back(32'h01);
      drive(1'b1, 32'h02, 0);
      exp_q.push_back(32'h02);
      drive(1'b0, '0, 4);
      @(negedge clk);
      check("t6_valid_ct", 64'(bus.dout_valid_ct), 2);
      drive(1'b0, '0, 0);
      @(negedge clk);
      check("t6_count", 64'(bus.count), 0);
      drive(1'b1, 32'h01, 0);
      exp_q.push_back(32'h01);
      drive(1'b1, 32'h02, 0);
      exp_q.push_back(32'h02);
      drive(1'b1, 32'h03, 4);
      exp_q.push_back(32'h03);
      @(negedge clk);
`ifdef MULTI_POP_FIFO_BYPASS_EN
      check("t6_push_valid_ct", 64'(bus.dout_valid_ct), 3);
      check("t6_push_lane2", 64'(lane(2)), 64'h03);
      drive(1'b0, '0, 0);
      @(negedge clk);
      check("t6_push_count", 64'(bus.count), 0);
`else
      check("t6_push_valid_ct", 64'(bus.dout_valid_ct), 2);
      drive(1'b0, '0, 0);
      @(negedge clk);
      check("t6_push_count", 64'(bus.count), 1);
      check("t6_push_lane0", 64'(lane(0)), 64'h03);
      drive(1'b0, '0, 1);
`endif
      // Following word lands behind the previous traffic in order.
      drive(1'b1, 32'h04, 0);
      exp_q.push_back(32'h04);
      drive(1'b0, '0, 0);
      @(negedge clk);
      check("t6_follow_count", 64'(bus.count), 1);
      check("t6_follow_lane0", 64'(lane(0)), 64'h04);
      drive(1'b0, '0, 1);
      drive(1'b0, '0, 0);
      @(negedge clk);
      check("t6_follow_drained", 64'(bus.count), 0);

      // Random-rate stream of 64 words across several pointer wraps.
      mcnt = 0;
      sent = 0;
      cyc  = 0;
      while ((sent < 64 || exp_q.size() != 0) && cyc < 3000) begin
         v = (sent < 64) && ($urandom_range(0, 3) != 0);
         r = int'($urandom_range(0, 4));
         drive(v, 32'h100 + 32'(sent), r);
         acc = v && (mcnt < 15);
         stored = (mcnt < 4) ? mcnt : 4;
         vct = stored;
`ifdef MULTI_POP_FIFO_BYPASS_EN
         if (acc && mcnt < 4) vct = vct + 1;
`endif
         pops = (vct < r) ? vct : r;
         if (acc) begin
            exp_q.push_back(32'h100 + 32'(sent));
            sent++;
         end
         @(negedge clk);
         check("rnd_count", 64'(bus.count), 64'(mcnt));
         check("rnd_din_ready", 64'(bus.din_ready), 64'(mcnt < 15));
         check("rnd_valid_ct", 64'(bus.dout_valid_ct), 64'(vct));
         mcnt = mcnt + int'(acc) - pops;
         cyc++;
      end
      check("rnd_cycle_budget", 64'(cyc < 3000), 1);
      check("rnd_all_sent", 64'(sent), 64);

      drive(1'b0, '0, 0);
      @(negedge clk);
      check("final_count", 64'(bus.count), 0);
      check("final_queue_empty", 64'(exp_q.size()), 0);
      mon_stop = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
